// File: rtl/mod_exp_pkg.sv
// Shared encodings and constants for the modular-exponentiation sequencer
// and its Montgomery-product launcher.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_X,
    ST_CONV_R,
    ST_SQUARE,
    ST_MULT,
    ST_CONV_OUT,
    ST_DONE
  } top_state_e;

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_ISSUE,
    LS_ARM,
    LS_WAIT
  } lch_state_e;

  // Zero-extended to the operand width at the point of use.
  localparam int unsigned ONE_OPERAND = 1;

  // Smallest index width with 2^w > exp_len.
  function automatic int cnt_w_for(input int exp_len);
    return $clog2(exp_len + 1);
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_mp_launcher.sv
// Runs one Montgomery product through the multiplier's start/stop handshake:
// ISSUE pulses mp_start, ARM waits for the stop level to drop, WAIT captures.
module mp_launcher
  import mod_exp_pkg::*;
#(
  parameter int BIT_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [BIT_LEN-1:0] a,
  input  logic [BIT_LEN-1:0] b,
  input  logic               mp_done,
  input  logic [BIT_LEN-1:0] mp_p,
  output logic               mp_start,
  output logic [BIT_LEN-1:0] mp_a,
  output logic [BIT_LEN-1:0] mp_b,
  output logic [BIT_LEN-1:0] product,
  output logic               ack,
  output logic [1:0]         dbg_state
);

  // Handshake: go is a 1-cycle request accepted only in LS_IDLE; ack is a
  // 1-cycle pulse the cycle after product has been captured.
  lch_state_e state, state_nx;

  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      LS_IDLE:  if (go) state_nx = LS_ISSUE;
      LS_ISSUE: state_nx = LS_ARM;
      // A stop level still high from the previous product is not completion.
      LS_ARM:   if (!mp_done) state_nx = LS_WAIT;
      LS_WAIT:  if (mp_done) state_nx = LS_IDLE;
      default:  state_nx = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LS_IDLE;
      mp_start <= 1'b0;
      mp_a     <= '0;
      mp_b     <= '0;
      product  <= '0;
      ack      <= 1'b0;
    end else begin
      state    <= state_nx;
      mp_start <= (state == LS_IDLE) && go;
      ack      <= (state == LS_WAIT) && mp_done;
      if (state == LS_IDLE && go) begin
        mp_a <= a;
        mp_b <= b;
      end
      if (state == LS_WAIT && mp_done) product <= mp_p;
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer in the Montgomery domain;
// every product is delegated to mp_launcher.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int BIT_LEN = 64,
  parameter int EXP_LEN = 64,
  parameter int CNT_W   = cnt_w_for(EXP_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BIT_LEN-1:0] base,
  input  logic [EXP_LEN-1:0] exponent,
  input  logic [BIT_LEN-1:0] modulus,
  input  logic [BIT_LEN-1:0] r2_mod,
  output logic               busy,
  output logic               done,
  output logic [BIT_LEN-1:0] result,
  output logic               mp_start,
  output logic [BIT_LEN-1:0] mp_a,
  output logic [BIT_LEN-1:0] mp_b,
  output logic [BIT_LEN-1:0] mp_m,
  input  logic               mp_done,
  input  logic [BIT_LEN-1:0] mp_p,
  output logic [2:0]         dbg_state,
  output logic [1:0]         dbg_lch_state
);

  localparam logic [BIT_LEN-1:0] ONE_B = BIT_LEN'(ONE_OPERAND);

  top_state_e         state, state_nx;
  logic [CNT_W-1:0]   idx;
  logic [BIT_LEN-1:0] x_r, r2_r, xm, am;
  logic [EXP_LEN-1:0] exp_r, exp_sh;
  logic               issued, go, ack, cur_bit, last_bit;
  logic [BIT_LEN-1:0] op_a, op_b, product;

  assign dbg_state = state;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign exp_sh    = exp_r >> idx;
  assign cur_bit   = exp_sh[0];
  assign last_bit  = (idx == '0);

  mp_launcher #(.BIT_LEN(BIT_LEN)) u_launcher (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .a         (op_a),
    .b         (op_b),
    .mp_done   (mp_done),
    .mp_p      (mp_p),
    .mp_start  (mp_start),
    .mp_a      (mp_a),
    .mp_b      (mp_b),
    .product   (product),
    .ack       (ack),
    .dbg_state (dbg_lch_state)
  );

  // Each product state launches once on entry and advances on ack.
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    op_a     = '0;
    op_b     = '0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_CONV_X;
      ST_CONV_X: begin
        op_a = x_r;
        op_b = r2_r;
        go   = !issued;
        if (ack) state_nx = ST_CONV_R;
      end
      ST_CONV_R: begin
        op_a = ONE_B;
        op_b = r2_r;
        go   = !issued;
        if (ack) state_nx = ST_SQUARE;
      end
      ST_SQUARE: begin
        op_a = am;
        op_b = am;
        go   = !issued;
        if (ack) begin
          if (cur_bit)       state_nx = ST_MULT;
          else if (last_bit) state_nx = ST_CONV_OUT;
          else               state_nx = ST_SQUARE;
        end
      end
      ST_MULT: begin
        op_a = am;
        op_b = xm;
        go   = !issued;
        if (ack) state_nx = last_bit ? ST_CONV_OUT : ST_SQUARE;
      end
      ST_CONV_OUT: begin
        op_a = am;
        op_b = ONE_B;
        go   = !issued;
        if (ack) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      issued <= 1'b0;
      x_r    <= '0;
      exp_r  <= '0;
      mp_m   <= '0;
      r2_r   <= '0;
      xm     <= '0;
      am     <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (ack)     issued <= 1'b0;
      else if (go) issued <= 1'b1;

      if (state == ST_IDLE && start) begin
        x_r   <= base;
        exp_r <= exponent;
        mp_m  <= modulus;
        r2_r  <= r2_mod;
        idx   <= CNT_W'(EXP_LEN - 1);
      end

      if (ack) begin
        case (state)
          ST_CONV_X: xm <= product;
          ST_CONV_R: am <= product;
          ST_SQUARE: begin
            am <= product;
            if (!cur_bit && !last_bit) idx <= idx - 1'b1;
          end
          ST_MULT: begin
            am <= product;
            if (!last_bit) idx <= idx - 1'b1;
          end
          // The multiplier leaves its output below 2M; one subtract normalises it.
          ST_CONV_OUT: result <= (product >= mp_m) ? product - mp_m : product;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with a behavioural radix-2 Montgomery multiplier
// of random latency; expected results come from a plain modular-power model.
module tb_mod_exp_ctrl;

  localparam int BL = 8;
  localparam int EL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BL-1:0] base = '0;
  logic [EL-1:0] exponent = '0;
  logic [BL-1:0] modulus = '0;
  logic [BL-1:0] r2_mod = '0;
  logic          busy, done, mp_start;
  logic [BL-1:0] result, mp_a, mp_b, mp_m;
  logic          mp_done = 1'b1;
  logic [BL-1:0] mp_p = '0;
  logic [2:0]    dbg_state;
  logic [1:0]    dbg_lch_state;

  int errors = 0;
  int checks = 0;
  int start_pulses = 0;
  int done_pulses = 0;
  int cur_m = 13;
  bit stale_mode = 1'b0;
  logic [BL-1:0] exp_q[$];

  mod_exp_ctrl #(.BIT_LEN(BL), .EXP_LEN(EL), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .r2_mod(r2_mod), .busy(busy), .done(done), .result(result),
    .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b), .mp_m(mp_m),
    .mp_done(mp_done), .mp_p(mp_p), .dbg_state(dbg_state), .dbg_lch_state(dbg_lch_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // a*b*2^-8 mod m, left unreduced below 2m
  function automatic int mont(input int a, input int b, input int m);
    int u;
    u = a * b;
    for (int i = 0; i < BL; i++) begin
      if (u % 2 != 0) u = u + m;
      u = u / 2;
    end
    return u;
  endfunction

  function automatic logic [BL-1:0] ref_modexp(input int x, input logic [EL-1:0] e, input int m);
    longint r;
    r = 1;
    for (int i = EL - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * x) % m;
    end
    return BL'(r);
  endfunction

  // behavioural multiplier: stop level stays high while idle
  int m_a, m_b, m_cnt, m_hold;
  bit m_busy = 1'b0;
  always @(posedge clk) begin
    if (mp_start === 1'b1) begin
      m_a    <= int'(mp_a);
      m_b    <= int'(mp_b);
      m_cnt  <= int'($urandom_range(3, 20));
      m_busy <= 1'b1;
      if (stale_mode) m_hold <= 2;
      else begin
        m_hold  <= 0;
        mp_done <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_hold > 0) begin
        m_hold <= m_hold - 1;
        if (m_hold == 1) mp_done <= 1'b0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else begin
        mp_p    <= BL'(mont(m_a, m_b, cur_m));
        mp_done <= 1'b1;
        m_busy  <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (mp_start === 1'b1) start_pulses++;
    if (done === 1'b1) done_pulses++;
  end

  // driver: launch one operation and queue its expected result
  task automatic run_op(input logic [BL-1:0] x, input logic [EL-1:0] e);
    @(negedge clk);
    start_pulses = 0;
    done_pulses  = 0;
    base     = x;
    exponent = e;
    modulus  = BL'(cur_m);
    r2_mod   = 8'd3;
    start    = 1'b1;
    exp_q.push_back(ref_modexp(int'(x), e, cur_m));
    @(negedge clk);
    start = 1'b0;
  endtask

  // scoreboard: wait for done, pop and compare
  task automatic wait_done(input string name);
    int n;
    logic [BL-1:0] exp_v;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
      void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_done: no queued expectation", name);
      return;
    end
    exp_v = exp_q.pop_front();
    if (result !== exp_v) begin
      errors++;
      $display("FAIL %s_result: got %0d expected %0d", name, result, exp_v);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b busy=%b expected 0/0", name, done, busy);
    end
  endtask

  task automatic check_pulses(input string name, input int expected);
    checks++;
    if (start_pulses !== expected) begin
      errors++;
      $display("FAIL %s_mp_start_count: got %0d expected %0d", name, start_pulses, expected);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result, mp_start, mp_a, mp_b, mp_m} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%0d mp_start=%b mp_a=%0d mp_b=%0d mp_m=%0d expected all 0",
               busy, done, result, mp_start, mp_a, mp_b, mp_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(8'd7, 8'd5);
    checks++;
    if (busy !== 1'b1 || mp_m !== 8'd13) begin
      errors++;
      $display("FAIL basic_busy_mpm: busy=%b mp_m=%0d expected 1/13", busy, mp_m);
    end
    wait_done("basic");
    check_pulses("basic", 13);
    checks++;
    if (done_pulses !== 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d expected 1", done_pulses);
    end
  endtask

  task automatic test_zero_exp();
    run_op(8'd7, 8'd0);
    wait_done("zero_exp");
    check_pulses("zero_exp", 11);
  endtask

  task automatic test_sequence();
    logic [BL-1:0] held;
    run_op(8'd12, 8'd1);
    wait_done("seq_e1");
    check_pulses("seq_e1", 12);
    held = ref_modexp(12, 8'd1, cur_m);
    repeat (20) @(negedge clk);
    checks++;
    if (result !== held) begin
      errors++;
      $display("FAIL seq_hold: got %0d expected %0d", result, held);
    end
    run_op(8'd2, 8'd255);
    wait_done("seq_e255");
    check_pulses("seq_e255", 19);
  endtask

  task automatic test_stale_done();
    stale_mode = 1'b1;
    run_op(8'd7, 8'd5);
    wait_done("stale");
    check_pulses("stale", 13);
    stale_mode = 1'b0;
  endtask

  task automatic test_start_while_busy();
    run_op(8'd7, 8'd5);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      base     = BL'($urandom_range(0, 255));
      exponent = EL'($urandom_range(0, 255));
      modulus  = BL'($urandom_range(0, 255));
      r2_mod   = BL'($urandom_range(0, 255));
      start    = (i % 2 == 0);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mp_m !== 8'd13) begin
      errors++;
      $display("FAIL busy_start_mpm: got %0d expected 13", mp_m);
    end
    wait_done("busy_start");
    repeat (5) @(negedge clk);
    checks++;
    if (done_pulses !== 1) begin
      errors++;
      $display("FAIL busy_start_done_count: got %0d expected 1", done_pulses);
    end
    check_pulses("busy_start", 13);
  endtask

  task automatic test_reset_mid_op();
    int n;
    int p0;
    run_op(8'd7, 8'd5);
    n = 0;
    // sixth product is the fourth SQUARE for E=5
    while (start_pulses < 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (start_pulses < 6) begin
      errors++;
      $display("FAIL rst_mid_reach: got %0d pulses expected 6", start_pulses);
    end
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    p0 = start_pulses;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, result, mp_start, mp_a, mp_b, mp_m} !== '0) begin
        errors++;
        $display("FAIL rst_mid_outputs: busy=%b done=%b result=%0d mp_start=%b mp_a=%0d mp_b=%0d mp_m=%0d expected all 0",
                 busy, done, result, mp_start, mp_a, mp_b, mp_m);
      end
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (start_pulses !== p0 || busy !== 1'b0 || done_pulses !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: pulses %0d->%0d busy=%b dones=%0d expected no activity",
               p0, start_pulses, busy, done_pulses);
    end
    run_op(8'd7, 8'd5);
    wait_done("rst_mid_rerun");
    check_pulses("rst_mid_rerun", 13);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_exp();
    test_sequence();
    test_stale_done();
    test_start_while_busy();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
